hamming_secded_dec: RTL and testbench

Pipelined, parametrised Hamming SECDED (single-error-correct, double-error-detect) decoder. It is the receive-side companion to the Hamming (11,7) encoder family, generalised to any data width plus an overall-parity bit. It accepts codewords over a valid/ready stream, corrects single-bit errors, flags uncorrectable errors, and keeps saturating error statistics. It sits between a storage or link receive path and the consuming logic.

---
 rtl/hamming_secded_dec.sv | 140 ++++++++++++++
 tb/tb_hamming_secded_dec.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dec.sv
// Pipelined Hamming SECDED decoder with valid/ready stream ports and saturating error counters.
// Stage 1 captures the codeword with its syndrome and global check; stage 2 corrects and classifies.
module hamming_secded_dec #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned P = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 :
                                (DATA_W <= 57) ? 6 : 7,
    localparam int unsigned CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_cor,
    output logic              out_unc,
    output logic [P-1:0]      out_syn,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_cor,
    output logic [CNT_W-1:0]  cnt_unc
);

    // Data bits occupy the non-power-of-two Hamming positions in ascending order.
    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d = {c[pos-1], d[DATA_W-1:1]};
            end
        end
        return d;
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_g;
    logic              s1_moves;
    logic              out_fire;

    logic [P-1:0]      syn_c;
    logic              g_c;
    logic [CODE_W-1:0] fixed_c;
    logic              cor_c;
    logic              unc_c;

    assign s1_moves = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_moves;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        syn_c = '0;
        for (int unsigned i = 0; i < CODE_W - 1; i++) begin
            if (in_code[i]) begin
                syn_c = syn_c ^ P'(i + 1);
            end
        end
        g_c = ^in_code;
    end

    // Syndrome pointing past the last Hamming position is treated as uncorrectable.
    always_comb begin
        fixed_c = s1_code;
        cor_c   = 1'b0;
        unc_c   = 1'b0;
        if (s1_syn == '0) begin
            cor_c = s1_g;
        end else if (!s1_g) begin
            unc_c = 1'b1;
        end else if (32'(s1_syn) <= CODE_W - 1) begin
            cor_c = 1'b1;
            for (int unsigned i = 0; i < CODE_W - 1; i++) begin
                if (P'(i + 1) == s1_syn) begin
                    fixed_c[i] = ~s1_code[i];
                end
            end
        end else begin
            unc_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_g     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn_c;
                s1_g    <= g_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cor   <= 1'b0;
            out_unc   <= 1'b0;
            out_syn   <= '0;
        end else if (s1_moves) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= extract(fixed_c);
                out_cor  <= cor_c;
                out_unc  <= unc_c;
                out_syn  <= s1_syn;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cor <= '0;
            cnt_unc <= '0;
        end else if (cnt_clr) begin
            cnt_cor <= '0;
            cnt_unc <= '0;
        end else if (out_fire) begin
            if (out_cor && (cnt_cor != '1)) begin
                cnt_cor <= cnt_cor + CNT_W'(1);
            end
            if (out_unc && (cnt_unc != '1)) begin
                cnt_unc <= cnt_unc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed bench for hamming_secded_dec: decode vectors, backpressure, counters and reset.
module tb_hamming_secded_dec;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [11:0] in_code;
    logic [6:0]  out_data;
    logic        out_cor, out_unc, cnt_clr;
    logic [3:0]  out_syn;
    logic [15:0] cnt_cor, cnt_unc;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [11:0] in_code2;
    logic [6:0]  out_data2;
    logic        out_cor2, out_unc2, cnt_clr2;
    logic [3:0]  out_syn2;
    logic [1:0]  cnt_cor2, cnt_unc2;

    int passed;
    int total;

    hamming_secded_dec #(.DATA_W(7), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cor(out_cor), .out_unc(out_unc), .out_syn(out_syn),
        .cnt_clr(cnt_clr), .cnt_cor(cnt_cor), .cnt_unc(cnt_unc)
    );

    hamming_secded_dec #(.DATA_W(7), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_cor(out_cor2), .out_unc(out_unc2), .out_syn(out_syn2),
        .cnt_clr(cnt_clr2), .cnt_cor(cnt_cor2), .cnt_unc(cnt_unc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] encode(input logic [6:0] d);
        logic [11:0] c;
        logic        p;
        int          j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 12; pos++) begin
                if (((pos >> k) & 1) == 1) p = p ^ c[pos-1];
            end
            c[(1 << k) - 1] = p;
        end
        c[11] = ^c[10:0];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_code = '0; out_ready = 1; cnt_clr = 0;
        in_valid2 = 0; in_code2 = '0; out_ready2 = 1; cnt_clr2 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if ({out_data, out_cor, out_unc, out_syn} !== 13'h0)
            $display("FAIL reset_fields got %h/%b/%b/%h want 0", out_data, out_cor, out_unc, out_syn); else passed++;
        total++; if (cnt_cor !== 16'd0 || cnt_unc !== 16'd0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_cor, cnt_unc); else passed++;
        total++; if (out_valid2 !== 1'b0 || cnt_cor2 !== 2'd0)
            $display("FAIL reset_dut2 got %b/%0d want 0/0", out_valid2, cnt_cor2); else passed++;
    endtask

    task automatic test_decode();
        logic [11:0] codes [6];
        logic [6:0]  datas [6];
        logic        cors  [6];
        logic        uncs  [6];
        logic [3:0]  syns  [6];
        int          exp_cor;
        int          exp_unc;
        codes = '{12'h807, 12'hFFF, 12'h817, 12'h7FF, 12'h804, 12'h089};
        datas = '{7'h01, 7'h7F, 7'h01, 7'h7F, 7'h01, 7'h00};
        cors  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        uncs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        syns  = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd3, 4'd13};
        exp_cor = 0;
        exp_unc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_code  = codes[i];
            tick();
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b0) $display("FAIL dec%0d_early_valid got %b want 0", i, out_valid); else passed++;
            tick();
            total++; if (out_valid !== 1'b1) $display("FAIL dec%0d_valid got %b want 1", i, out_valid); else passed++;
            total++; if (out_data !== datas[i]) $display("FAIL dec%0d_data got %h want %h", i, out_data, datas[i]); else passed++;
            total++; if (out_cor !== cors[i] || out_unc !== uncs[i])
                $display("FAIL dec%0d_flags got cor=%b unc=%b want cor=%b unc=%b", i, out_cor, out_unc, cors[i], uncs[i]); else passed++;
            total++; if (out_syn !== syns[i]) $display("FAIL dec%0d_syn got %0d want %0d", i, out_syn, syns[i]); else passed++;
            if (cors[i]) exp_cor++;
            if (uncs[i]) exp_unc++;
            tick();
            total++; if (cnt_cor !== 16'(exp_cor) || cnt_unc !== 16'(exp_unc))
                $display("FAIL dec%0d_counters got %0d/%0d want %0d/%0d", i, cnt_cor, cnt_unc, exp_cor, exp_unc); else passed++;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL dec_drained got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_saturate();
        out_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            in_code2  = 12'h817;
            total++; if (in_ready2 !== 1'b1) $display("FAIL sat_in_ready%0d got %b want 1", i, in_ready2); else passed++;
            tick();
        end
        in_valid2 = 1'b0;
        repeat (3) tick();
        total++; if (cnt_cor2 !== 2'd3) $display("FAIL sat_cnt_cor got %0d want 3", cnt_cor2); else passed++;
        total++; if (cnt_unc2 !== 2'd0) $display("FAIL sat_cnt_unc got %0d want 0", cnt_unc2); else passed++;
    endtask

    task automatic test_backpressure();
        logic [6:0] exp_q [$];
        logic [6:0] pend;
        logic [6:0] prev_data;
        logic [6:0] want;
        logic       prev_stall;
        logic       in_fire, out_fire;
        int         sent, recv, occ, cyc;
        sent = 0; recv = 0; occ = 0; cyc = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        in_valid   = 1'b0;
        while (recv < 8 && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < 8) begin
                pend     = 7'($urandom);
                in_code  = encode(pend);
                in_valid = 1'b1;
            end
            #1;
            total++; if (in_ready !== !(occ == 2 && !out_ready))
                $display("FAIL bp_in_ready cyc%0d got %b want %b (occ=%0d)", cyc, in_ready, !(occ == 2 && !out_ready), occ); else passed++;
            if (prev_stall) begin
                total++; if (out_valid !== 1'b1 || out_data !== prev_data)
                    $display("FAIL bp_hold cyc%0d got %b/%h want 1/%h", cyc, out_valid, out_data, prev_data); else passed++;
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL bp_extra_word got %h want none", out_data);
                end else begin
                    want = exp_q.pop_front();
                    total++; if (out_data !== want || out_cor !== 1'b0 || out_unc !== 1'b0)
                        $display("FAIL bp_word%0d got %h cor=%b unc=%b want %h 0 0", recv, out_data, out_cor, out_unc, want); else passed++;
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_fire) begin
                exp_q.push_back(pend);
                sent++;
            end
            occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
            @(posedge clk);
            @(negedge clk);
            if (in_fire) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (recv != 8) $display("FAIL bp_count got %0d want 8", recv); else passed++;
        out_ready = 1'b1;
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_clr();
        total++; if (cnt_cor !== 16'd2) $display("FAIL clr_pre got %0d want 2", cnt_cor); else passed++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 12'h817;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if (out_valid !== 1'b1 || out_cor !== 1'b1)
            $display("FAIL clr_stalled got %b/%b want 1/1", out_valid, out_cor); else passed++;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (cnt_cor !== 16'd0 || cnt_unc !== 16'd0)
            $display("FAIL clr_same_cycle got %0d/%0d want 0/0", cnt_cor, cnt_unc); else passed++;
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 12'h804;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if (cnt_unc !== 16'd1) $display("FAIL rf_pre_unc got %0d want 1", cnt_unc); else passed++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 12'h817;
        tick();
        in_code = 12'h807;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL rf_full got valid=%b ready=%b want 1/0", out_valid, in_ready); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || cnt_unc !== 16'd0 || cnt_cor !== 16'd0)
            $display("FAIL rf_async got %b/%0d/%0d want 0/0/0", out_valid, cnt_unc, cnt_cor); else passed++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) $display("FAIL rf_ghost%0d got %b want 0", i, out_valid); else passed++;
        end
        total++; if (in_ready !== 1'b1 || cnt_cor !== 16'd0)
            $display("FAIL rf_after got ready=%b cnt=%0d want 1/0", in_ready, cnt_cor); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_decode();
        test_saturate();
        test_backpressure();
        test_clr();
        test_reset_flight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
